// File: rtl/gate_selftest.sv
// Sequencing stimulus/checker for an N-input combinational gate: walks every input
// vector, compares the gate output against TRUTH and reports pass/err_cnt/first fail.
// Optional: define GATE_SELFTEST_STOP_ON_FAIL_EN to end the run on the first mismatch.
module gate_selftest #(
  parameter int N_IN   = 2,
  parameter int SETTLE = 1,
  parameter     TRUTH  = 4'b1000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic [N_IN-1:0] stim,
  input  logic            dut_o,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_cnt,
  output logic            fail_valid,
  output logic [N_IN-1:0] fail_vec
);
  localparam int            NV = 1 << N_IN;
  localparam logic [NV-1:0] TT = NV'(TRUTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;

  logic [3:0] cnt;
  logic       cmp, mis, last, finish, accept;

  always_comb begin
    cmp    = (state == RUN) && (cnt == 4'(SETTLE));
    // Case inequality so an X/Z gate output is scored as a mismatch.
    mis    = cmp && (dut_o !== TT[stim]);
    last   = &stim;
`ifdef GATE_SELFTEST_STOP_ON_FAIL_EN
    finish = cmp && (last || mis);
`else
    finish = cmp && last;
`endif
    accept = start && (state != RUN);
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (finish) state_nx = DONE;
      DONE:    state_nx = start ? RUN : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stim       <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_cnt    <= '0;
      fail_valid <= 1'b0;
      fail_vec   <= '0;
      cnt        <= '0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        busy       <= 1'b1;
        stim       <= '0;
        cnt        <= '0;
        err_cnt    <= '0;
        fail_valid <= 1'b0;
        pass       <= 1'b0;
      end else if (state == RUN) begin
        if (mis) begin
          err_cnt <= err_cnt + 1'b1;
          if (!fail_valid) begin
            fail_vec   <= stim;
            fail_valid <= 1'b1;
          end
        end
        if (cmp) begin
          cnt <= '0;
          if (finish) begin
            busy <= 1'b0;
            done <= 1'b1;
            stim <= '0;
            pass <= (err_cnt == '0) && !mis;
          end else begin
            stim <= stim + 1'b1;
          end
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_gate_selftest.sv
// Randomised bench for gate_selftest: a table-driven gate model plus a reference
// computed from the truth-table rules (mismatch list, run length, done cycle).
module tb_gate_selftest;
  localparam int            N_IN   = 2;
  localparam int            SETTLE = 1;
  localparam int            NV     = 1 << N_IN;
  localparam logic [NV-1:0] TRUTH  = 4'b1000;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic [N_IN-1:0] stim;
  logic            dut_o;
  logic            busy, done, pass, fail_valid;
  logic [N_IN:0]   err_cnt;
  logic [N_IN-1:0] fail_vec;
  logic [NV-1:0]   gate_tbl = 4'b1000;

  int checks = 0;
  int fails  = 0;

  gate_selftest #(.N_IN(N_IN), .SETTLE(SETTLE), .TRUTH(TRUTH)) dut (
    .clk(clk), .rst(rst), .start(start), .stim(stim), .dut_o(dut_o),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
    .fail_valid(fail_valid), .fail_vec(fail_vec)
  );

  always #5 clk = ~clk;
  assign dut_o = gate_tbl[stim];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full run from a start pulse; expected values come from the truth-table rules.
  task automatic run_and_check(input logic [NV-1:0] g, input string name);
    int first, nerr, napp, dcyc;
    logic [N_IN-1:0] exp_stim;
    gate_tbl = g;
    first = -1;
    nerr  = 0;
    for (int v = 0; v < NV; v++)
      if (g[v] !== TRUTH[v]) begin
        nerr++;
        if (first < 0) first = v;
      end
`ifdef GATE_SELFTEST_STOP_ON_FAIL_EN
    napp = (first < 0) ? NV : first + 1;
    nerr = (first < 0) ? 0 : 1;
`else
    napp = NV;
`endif
    dcyc = napp * (SETTLE + 1) + 1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= dcyc; k++) begin
      checks++;
      if (k < dcyc) begin
        exp_stim = N_IN'((k - 1) / (SETTLE + 1));
        if ({busy, done, stim} !== {1'b1, 1'b0, exp_stim}) begin
          fails++;
          $display("FAIL %s run cyc%0d busy/done/stim got %b/%b/%0d want 1/0/%0d",
                   name, k, busy, done, stim, exp_stim);
        end
      end else begin
        if ({busy, done, stim, pass, err_cnt, fail_valid} !==
            {1'b0, 1'b1, N_IN'(0), (nerr == 0), (N_IN+1)'(nerr), (first >= 0)} ||
            (first >= 0 && fail_vec !== N_IN'(first))) begin
          fails++;
          $display("FAIL %s done cyc%0d busy/done/stim/pass/err/fv/vec got %b/%b/%0d/%b/%0d/%b/%0d want 0/1/0/%0b/%0d/%0b/%0d",
                   name, k, busy, done, stim, pass, err_cnt, fail_valid, fail_vec,
                   (nerr == 0), nerr, (first >= 0), first);
        end
      end
      tick();
    end
    checks++;
    if ({busy, done, stim, pass, err_cnt} !== {1'b0, 1'b0, N_IN'(0), (nerr == 0), (N_IN+1)'(nerr)}) begin
      fails++;
      $display("FAIL %s hold busy/done/stim/pass/err got %b/%b/%0d/%b/%0d want 0/0/0/%0b/%0d",
               name, busy, done, stim, pass, err_cnt, (nerr == 0), nerr);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({stim, busy, done, pass, err_cnt, fail_valid, fail_vec} !== '0) begin
      fails++;
      $display("FAIL reset outputs got %b want 0", {stim, busy, done, pass, err_cnt, fail_valid, fail_vec});
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_directed();
    run_and_check(4'b1000, "and");
    run_and_check(4'b0000, "stuck0");
    run_and_check(4'b0111, "nand");
    run_and_check(4'b10x0, "xout");
  endtask

  task automatic test_mid_reset();
    gate_tbl = 4'b1000;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({stim, busy, done, pass, err_cnt, fail_valid, fail_vec} !== '0) begin
      fails++;
      $display("FAIL midreset outputs got %b want 0", {stim, busy, done, pass, err_cnt, fail_valid, fail_vec});
    end
    tick();
    checks++;
    if ({busy, done} !== 2'b00) begin
      fails++;
      $display("FAIL midreset nodone busy/done got %b%b want 00", busy, done);
    end
    run_and_check(4'b1000, "after_rst");
  endtask

  task automatic test_back_to_back();
    logic            eb, ed;
    logic [N_IN-1:0] es;
    gate_tbl = 4'b1000;
    start = 1'b1;
    tick();
    for (int k = 1; k <= 18; k++) begin
      start = (k <= 12);
      ed = (k == 9) || (k == 18);
      eb = (k < 9) || (k > 9 && k < 18);
      es = (k < 9) ? N_IN'((k - 1) / 2) : (k > 9 && k < 18) ? N_IN'((k - 10) / 2) : N_IN'(0);
      checks++;
      if ({busy, done, stim} !== {eb, ed, es}) begin
        fails++;
        $display("FAIL b2b cyc%0d busy/done/stim got %b/%b/%0d want %b/%b/%0d",
                 k, busy, done, stim, eb, ed, es);
      end
      tick();
    end
    start = 1'b0;
    checks++;
    if ({busy, pass, err_cnt} !== {1'b0, 1'b1, (N_IN+1)'(0)}) begin
      fails++;
      $display("FAIL b2b result busy/pass/err got %b/%b/%0d want 0/1/0", busy, pass, err_cnt);
    end
  endtask

  task automatic test_random();
    logic [NV-1:0] g;
    for (int i = 0; i < 8; i++) begin
      g = NV'($urandom_range(0, NV - 1 + NV * 3));
      if ($urandom_range(0, 3) == 0) g[$urandom_range(0, NV - 1)] = 1'bx;
      run_and_check(g, "rand");
      repeat ($urandom_range(0, 2)) tick();
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_mid_reset();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
